fetch_prefetch_unit: RTL and testbench
======================================

// Module: fetch_prefetch_unit
// PURPOSE
//  Parametrised fetch stage: owns the PC, issues sequential reads to a 1-cycle synchronous instruction memory,
//  buffers returned words in a DEPTH-entry prefetch queue, hands {pc,inst} to decode over valid/ready.
//  Redirects (jump/call/ret/fixed vector) flush queue and in-flight read. Sits between INST_MEM and decode.
// PARAMETERS
//  ADDR_W    32   PC / memory address width
//  INST_W    16   instruction word width
//  DEPTH     4    prefetch queue entries (power of 2, >=2)
//  RESET_VEC 0    PC value loaded on rst
//  VEC_STEP  2    spacing of fixed vectors (vector n -> n*VEC_STEP)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  redir_vld  in   1       redirect request this cycle
//  redir_sel  in   2       0=ABS(redir_addr) 1=FIXED(redir_idx*VEC_STEP) 2=IVT(ivt_base+redir_idx) 3=reserved(ABS)
//  redir_addr in   ADDR_W  absolute target (ret / call, caller zero-extends)
//  redir_idx  in   3       vector / IVT index
//  ivt_base   in   ADDR_W  IVT base address (present only with FETCH_IVT_EN)
//  imem_req   out  1       read strobe
//  imem_addr  out  ADDR_W  read address
//  imem_data  in   INST_W  read data, valid exactly 1 cycle after imem_req
//  dec_vld    out  1       queue head valid
//  dec_rdy    in   1       decode accepts head
//  dec_inst   out  INST_W  head instruction
//  dec_pc     out  ADDR_W  head PC
// BEHAVIOUR
//  - Reset: pc<=RESET_VEC, queue empty, count=0, inflight=0, epoch=0; imem_req=0, dec_vld=0, dec_inst=0, dec_pc=0.
//  - Issue: imem_req=1 when !rst && !redir_vld && (count+inflight+1 <= DEPTH) (pop this cycle does not free room);
//    imem_addr=pc; pc<=pc+1 (mod 2^ADDR_W, wraps silently); inflight<=1 carrying {epoch,pc}.
//  - Return: cycle after issue, if tag epoch==epoch push {pc,imem_data}; else discard.
//  - Pop: dec_vld&&dec_rdy removes head. Push+pop same cycle: count unchanged. Full: no issue, no overflow possible.
//  - dec_inst/dec_pc hold head contents; undefined-free (hold last) when dec_vld=0; registered queue, no comb path imem->dec.
//  - Redirect (redir_vld=1): pc<=target, queue flushed (count<=0), epoch toggles, no issue that cycle;
//    in-flight response arriving next cycle is discarded. dec_vld drops next cycle; head pop in redirect cycle is legal, still accepted.
//  - Fetch latency: redirect at cycle N -> imem_req at N+1 -> dec_vld at N+3 (queue registered).
//  - Priority: rst > redir_vld > sequential issue/push/pop. Back-to-back redirects: last wins, each flushes.
//  - Target arithmetic: FIXED = zero-extended redir_idx*VEC_STEP; IVT = ivt_base + zero-extended redir_idx, mod 2^ADDR_W.
//  - rst mid-operation: all state cleared same edge, in-flight data dropped (inflight<=0).
// CONFIGURATION
//  FETCH_IVT_EN defined: ivt_base port exists, redir_sel=2 computes ivt_base+redir_idx.
//  FETCH_IVT_EN undefined: no ivt_base port; redir_sel=2 treated as ABS (redir_addr).
// STRUCTURE
//  Package fetch_pkg: redir_sel encodings (RSEL_ABS/FIXED/IVT), pc_t/inst_t widths, fetch_entry_t {pc,inst}.
//  Sub-module fetch_queue: DEPTH-entry sync FIFO with push/pop/flush, count, full/empty; top holds PC, epoch, issue logic.
// TESTING
//  1 Reset then dec_rdy=1, mem[i]=0x1000+i -> dec_vld at cycle 3, stream pc 0,1,2,.. inst 0x1000,0x1001,.. one per cycle.
//  2 dec_rdy=0 for 10 cycles -> exactly 4 entries held (DEPTH=4), imem_req low once full; release -> pc 0..3 in order, no loss/dup.
//  3 redir ABS 0x40 while queue holds 3 and read in flight -> stale words never reach decode; next dec_pc=0x40.
//  4 redir FIXED idx=3 -> next dec_pc=6; idx=0 -> 0.
//  5 FETCH_IVT_EN, ivt_base=0x100, idx=5 -> dec_pc=0x105; undefined build, redir_addr=0x80 -> dec_pc=0x80.
//  6 pc=2^ADDR_W-1 sequential -> next pc 0; rst asserted mid-stream -> dec_vld=0 next cycle, restart at RESET_VEC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: redirect selector encodings and
// default-width PC / instruction / queue-entry types.
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int INST_W_DEF = 16;

    localparam logic [1:0] RSEL_ABS   = 2'd0;
    localparam logic [1:0] RSEL_FIXED = 2'd1;
    localparam logic [1:0] RSEL_IVT   = 2'd2;
    localparam logic [1:0] RSEL_RSVD  = 2'd3;

    typedef logic [ADDR_W_DEF-1:0] pc_t;
    typedef logic [INST_W_DEF-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO with push/pop/flush; the head output holds the
// last presented entry while the queue is empty.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    output logic [DATA_W-1:0]        o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_hold;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count = r_count;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = o_empty ? r_hold : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // r_hold tracks whatever the head showed before it went away, so the
    // decode-side outputs never jump to stale array contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            if (!o_empty) begin
                r_hold <= r_mem[r_rd_ptr];
            end
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr];
            end
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the PC, issues sequential 1-cycle reads, buffers returns in
// fetch_queue and presents {pc,inst} to decode. FETCH_IVT_EN adds ivt_base.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 16,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                VEC_STEP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redir_vld,
    input  logic [1:0]        redir_sel,
    input  logic [ADDR_W-1:0] redir_addr,
    input  logic [2:0]        redir_idx,
`ifdef FETCH_IVT_EN
    input  logic [ADDR_W-1:0] ivt_base,
`endif
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              dec_vld,
    input  logic              dec_rdy,
    output logic [INST_W-1:0] dec_inst,
    output logic [ADDR_W-1:0] dec_pc
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int DATA_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] r_pc;
    logic              r_epoch;
    logic              r_inflight;
    logic              r_tag_epoch;
    logic [ADDR_W-1:0] r_tag_pc;

    logic [ADDR_W-1:0] w_target;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_used;
    logic              w_full;
    logic              w_empty;
    logic              w_room;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;

    always_comb begin
        w_target = redir_addr;
        case (redir_sel)
            RSEL_FIXED: w_target = ADDR_W'(redir_idx) * ADDR_W'(VEC_STEP);
`ifdef FETCH_IVT_EN
            RSEL_IVT:   w_target = ivt_base + ADDR_W'(redir_idx);
`endif
            default:    w_target = redir_addr;
        endcase
    end

    // A pop this cycle does not count as free room: issue looks only at
    // what is already stored plus the read still on its way back.
    assign w_used  = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_inflight);
    assign w_room  = w_used < (CNT_W+1)'(DEPTH);
    assign w_issue = !rst && !redir_vld && !w_full && w_room;

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    assign w_push = r_inflight && (r_tag_epoch == r_epoch) && !redir_vld;
    assign w_pop  = dec_vld && dec_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_VEC;
            r_epoch     <= 1'b0;
            r_inflight  <= 1'b0;
            r_tag_epoch <= 1'b0;
            r_tag_pc    <= '0;
        end else if (redir_vld) begin
            r_pc       <= w_target;
            r_epoch    <= ~r_epoch;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc        <= r_pc + 1'b1;
                r_tag_pc    <= r_pc;
                r_tag_epoch <= r_epoch;
            end
        end
    end

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redir_vld),
        .i_push      (w_push),
        .i_push_data ({r_tag_pc, imem_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign dec_vld  = !w_empty;
    assign dec_pc   = w_head[DATA_W-1:INST_W];
    assign dec_inst = w_head[INST_W-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: memory model returns 0x1000+addr,
// expected PCs/instructions are hand-computed constants.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        redir_vld;
    logic [1:0]  redir_sel;
    logic [31:0] redir_addr;
    logic [2:0]  redir_idx;
`ifdef FETCH_IVT_EN
    logic [31:0] ivt_base;
`endif
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        dec_vld;
    logic        dec_rdy;
    logic [15:0] dec_inst;
    logic [31:0] dec_pc;

    int n_total;
    int n_bad;

    fetch_prefetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .redir_vld  (redir_vld),
        .redir_sel  (redir_sel),
        .redir_addr (redir_addr),
        .redir_idx  (redir_idx),
`ifdef FETCH_IVT_EN
        .ivt_base   (ivt_base),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dec_vld    (dec_vld),
        .dec_rdy    (dec_rdy),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle synchronous instruction memory: word at addr is 0x1000+addr
    initial imem_data = 16'h0;
    always @(posedge clk) begin
        if (imem_req) imem_data <= 16'(32'h1000 + imem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        redir_vld = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        settle();
    endtask

    // Redirect for one cycle, then check N+1 issue and N+3 head with decode stalled.
    task automatic do_redir(input string tag, input logic [1:0] sel, input logic [31:0] addr,
                            input logic [2:0] idx, input logic [31:0] exp_pc);
        dec_rdy    = 1'b0;
        redir_vld  = 1'b1;
        redir_sel  = sel;
        redir_addr = addr;
        redir_idx  = idx;
        settle();
        chk({tag, "_req_n"}, 64'(imem_req), 64'd0);
        cyc();
        redir_vld = 1'b0;
        settle();
        chk({tag, "_req_n1"}, 64'(imem_req), 64'd1);
        chk({tag, "_addr_n1"}, 64'(imem_addr), 64'(exp_pc));
        cyc();
        settle();
        chk({tag, "_vld_n2"}, 64'(dec_vld), 64'd0);
        cyc();
        settle();
        chk({tag, "_vld_n3"}, 64'(dec_vld), 64'd1);
        chk({tag, "_pc_n3"}, 64'(dec_pc), 64'(exp_pc));
        chk({tag, "_inst_n3"}, 64'(dec_inst), 64'(16'(32'h1000 + exp_pc)));
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        redir_vld  = 1'b0;
        redir_sel  = 2'd0;
        redir_addr = 32'h0;
        redir_idx  = 3'd0;
        dec_rdy    = 1'b1;
`ifdef FETCH_IVT_EN
        ivt_base   = 32'h100;
`endif
        cyc();
        settle();
        chk("rst_vld", 64'(dec_vld), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_pc", 64'(dec_pc), 64'd0);
        chk("rst_inst", 64'(dec_inst), 64'd0);

        // 1: streaming from reset
        reset_dut();
        chk("t1_req_c1", 64'(imem_req), 64'd1);
        chk("t1_addr_c1", 64'(imem_addr), 64'd0);
        chk("t1_vld_c1", 64'(dec_vld), 64'd0);
        cyc();
        settle();
        chk("t1_vld_c2", 64'(dec_vld), 64'd0);
        cyc();
        settle();
        chk("t1_vld_c3", 64'(dec_vld), 64'd1);
        chk("t1_pc_c3", 64'(dec_pc), 64'd0);
        chk("t1_inst_c3", 64'(dec_inst), 64'h1000);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            settle();
            chk("t1_stream_vld", 64'(dec_vld), 64'd1);
            chk("t1_stream_pc", 64'(dec_pc), 64'(k));
            chk("t1_stream_inst", 64'(dec_inst), 64'(32'h1000 + k));
        end

        // 2: stall decode; queue fills with pcs 5..8, pc stops at 9
        dec_rdy = 1'b0;
        for (int k = 0; k < 10; k++) cyc();
        settle();
        chk("t2_req_full", 64'(imem_req), 64'd0);
        chk("t2_addr_full", 64'(imem_addr), 64'd9);
        chk("t2_vld_full", 64'(dec_vld), 64'd1);
        chk("t2_pc_full", 64'(dec_pc), 64'd5);
        dec_rdy = 1'b1;
        settle();
        for (int k = 5; k <= 10; k++) begin
            chk("t2_drain_pc", 64'(dec_pc), 64'(k));
            chk("t2_drain_inst", 64'(dec_inst), 64'(32'h1000 + k));
            cyc();
            settle();
        end

        // 3: redirect with 3 queued + 1 in flight; stale words must not appear
        dec_rdy = 1'b0;
        reset_dut();
        for (int k = 0; k < 4; k++) cyc();
        settle();
        chk("t3_pre_pc", 64'(dec_pc), 64'd0);
        chk("t3_pre_req", 64'(imem_req), 64'd0);
        do_redir("t3_abs", 2'd0, 32'h40, 3'd0, 32'h40);

        // 4: fixed vectors
        do_redir("t4_fix3", 2'd1, 32'hdead, 3'd3, 32'h6);
        do_redir("t4_fix0", 2'd1, 32'hdead, 3'd0, 32'h0);

        // 5: IVT select (or ABS fallback) and reserved select
`ifdef FETCH_IVT_EN
        do_redir("t5_ivt", 2'd2, 32'h80, 3'd5, 32'h105);
`else
        do_redir("t5_ivt_abs", 2'd2, 32'h80, 3'd5, 32'h80);
`endif
        do_redir("t5_rsvd", 2'd3, 32'h90, 3'd7, 32'h90);

        // back-to-back redirects: the second target wins
        redir_vld  = 1'b1;
        redir_sel  = 2'd0;
        redir_addr = 32'h40;
        cyc();
        do_redir("t5_b2b", 2'd0, 32'h50, 3'd0, 32'h50);

        // 6: PC wrap, then reset mid-stream
        do_redir("t6_wrap", 2'd0, 32'hffff_ffff, 3'd0, 32'hffff_ffff);
        dec_rdy = 1'b1;
        cyc();
        settle();
        chk("t6_wrap_pc", 64'(dec_pc), 64'd0);
        chk("t6_wrap_inst", 64'(dec_inst), 64'h1000);
        cyc();
        settle();
        chk("t6_wrap_pc1", 64'(dec_pc), 64'd1);
        rst = 1'b1;
        cyc();
        settle();
        chk("t6_rst_vld", 64'(dec_vld), 64'd0);
        chk("t6_rst_req", 64'(imem_req), 64'd0);
        chk("t6_rst_pc", 64'(dec_pc), 64'd0);
        rst = 1'b0;
        settle();
        chk("t6_restart_addr", 64'(imem_addr), 64'd0);
        chk("t6_restart_req", 64'(imem_req), 64'd1);
        cyc();
        cyc();
        settle();
        chk("t6_restart_vld", 64'(dec_vld), 64'd1);
        chk("t6_restart_pc", 64'(dec_pc), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
